// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: access size, FSM state, port owner.
// Also holds the alignment rule used by both request selection and error handling.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      BYTE      = 2'd0,
      HALF_WORD = 2'd1,
      WORD      = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      ERR_D  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_D  = 1'b1
   } mem_owner_t;

   function automatic logic misaligned(input logic [1:0] off, input mem_size_t size);
      case (size)
         HALF_WORD: return off[0];
         WORD:      return off != 2'b00;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Combinational lane logic: store byte enables and lane replication on the request side,
// load shift and sign/zero extension on the response side. Zero latency, no flow control.
module lsu_align
   import mem_port_arbiter_pkg::*;
(
   input  mem_size_t   req_size,
   input  logic [1:0]  req_off,
   input  logic [31:0] req_wdata,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata_rep,
   input  mem_size_t   rsp_size,
   input  logic [1:0]  rsp_off,
   input  logic        rsp_zext,
   input  logic [31:0] rsp_rdata,
   output logic [31:0] rsp_data
);

   logic [31:0] shifted;

   always_comb begin
      req_be        = 4'hF;
      req_wdata_rep = req_wdata;
      case (req_size)
         BYTE: begin
            req_be        = 4'b0001 << req_off;
            req_wdata_rep = {4{req_wdata[7:0]}};
         end
         HALF_WORD: begin
            req_be        = 4'b0011 << req_off;
            req_wdata_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted  = rsp_rdata >> {rsp_off, 3'b000};
      rsp_data = shifted;
      case (rsp_size)
         BYTE:      rsp_data = rsp_zext ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
         HALF_WORD: rsp_data = rsp_zext ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one memory port, one transaction in flight;
// zero-latency grant in IDLE, response passed through the cycle mem_rvalid (or timeout) arrives.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_PRIORITY  = 1,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dmem_req,
   input  logic [31:0] dmem_addr,
   input  logic        dmem_wr_en,
   input  mem_size_t   dmem_size,
   input  logic        dmem_zero_extend,
   input  logic [31:0] dmem_wdata,
   output logic        dmem_gnt,
   output logic        dmem_rvalid,
   output logic [31:0] dmem_rdata,
   output logic        dmem_err,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int          CNT_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   arb_state_t       state_q, state_d;
   mem_owner_t       last_owner_q, last_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       off_q, off_d;
   mem_size_t        size_q, size_d;
   logic             zext_q, zext_d;
   logic             we_q, we_d;

   logic        is_idle, d_mis, sel_d, sel_if, done;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;

   lsu_align u_lsu_align (
      .req_size      (dmem_size),
      .req_off       (dmem_addr[1:0]),
      .req_wdata     (dmem_wdata),
      .req_be        (st_be),
      .req_wdata_rep (st_wdata),
      .rsp_size      (size_q),
      .rsp_off       (off_q),
      .rsp_zext      (zext_q),
      .rsp_rdata     (mem_rdata),
      .rsp_data      (ld_data)
   );

   // Outputs are gated by reset so nothing leaks out while it is held.
   always_comb begin
      is_idle = (state_q == IDLE) && !reset;
      d_mis   = misaligned(dmem_addr[1:0], dmem_size);
      sel_d   = is_idle && dmem_req &&
                (!if_req || (DATA_PRIORITY != 0) || (last_owner_q == OWNER_IF));
      sel_if  = is_idle && if_req && !sel_d;
      done    = mem_rvalid || (cnt_q == CNT_LAST);
   end

   always_comb begin
      mem_req   = sel_if || (sel_d && !d_mis);
      if_gnt    = sel_if && mem_gnt;
      dmem_gnt  = sel_d && (d_mis || mem_gnt);
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_wdata = '0;
      if (sel_if) begin
         mem_addr = if_addr & WORD_MASK;
         mem_be   = 4'hF;
      end else if (sel_d && !d_mis) begin
         mem_addr  = dmem_addr & WORD_MASK;
         mem_we    = dmem_wr_en;
         mem_be    = dmem_wr_en ? st_be : 4'hF;
         mem_wdata = dmem_wr_en ? st_wdata : '0;
      end
   end

   always_comb begin
      if_rvalid   = 1'b0;
      if_rdata    = '0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      dmem_err    = 1'b0;
      if (!reset) begin
         case (state_q)
            BUSY_I: begin
               if_rvalid = done;
               if_rdata  = mem_rvalid ? mem_rdata : '0;
            end
            BUSY_D: begin
               dmem_rvalid = done;
               dmem_err    = done && !mem_rvalid;
               dmem_rdata  = (mem_rvalid && !we_q) ? ld_data : '0;
            end
            ERR_D: begin
               dmem_rvalid = 1'b1;
               dmem_err    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      off_d        = off_q;
      size_d       = size_q;
      zext_d       = zext_q;
      we_d         = we_q;
      case (state_q)
         IDLE: begin
            if (if_gnt) begin
               state_d      = BUSY_I;
               last_owner_d = OWNER_IF;
               cnt_d        = '0;
            end else if (dmem_gnt) begin
               state_d      = d_mis ? ERR_D : BUSY_D;
               last_owner_d = OWNER_D;
               cnt_d        = '0;
               off_d        = dmem_addr[1:0];
               size_d       = dmem_size;
               zext_d       = dmem_zero_extend;
               we_d         = dmem_wr_en;
            end
         end
         BUSY_I, BUSY_D: begin
            cnt_d = cnt_q + 1'b1;
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= OWNER_IF;
         cnt_q        <= '0;
         off_q        <= 2'b00;
         size_q       <= BYTE;
         zext_q       <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         off_q        <= off_d;
         size_q       <= size_d;
         zext_q       <= zext_d;
         we_q         <= we_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a data-priority instance and a round-robin instance share stimulus;
// responses are matched against a queue of expected responses filled at grant time.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req, dmem_req, dmem_wr_en, dmem_zero_extend, mem_gnt, mem_rvalid;
   logic [31:0] if_addr, dmem_addr, dmem_wdata, mem_rdata;
   mem_size_t   dmem_size;

   logic        a_if_gnt, a_if_rvalid, a_dmem_gnt, a_dmem_rvalid, a_dmem_err, a_mem_req, a_mem_we;
   logic [31:0] a_if_rdata, a_dmem_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_if_gnt, b_if_rvalid, b_dmem_gnt, b_dmem_rvalid, b_dmem_err, b_mem_req, b_mem_we;
   logic [31:0] b_if_rdata, b_dmem_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_be;

   logic        o_if_gnt, o_if_rvalid, o_dmem_gnt, o_dmem_rvalid, o_dmem_err, o_mem_req, o_mem_we;
   logic [31:0] o_if_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic [138:0] o_all;

   bit   mon_rr = 1'b0;
   int   checks = 0;
   int   errors = 0;
   rsp_t exp_q[$];
   rsp_t mon_e, mon_g;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en), .dmem_size(dmem_size),
      .dmem_zero_extend(dmem_zero_extend), .dmem_wdata(dmem_wdata), .dmem_gnt(a_dmem_gnt),
      .dmem_rvalid(a_dmem_rvalid), .dmem_rdata(a_dmem_rdata), .dmem_err(a_dmem_err),
      .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_be(a_mem_be),
      .mem_wdata(a_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(16)) dut_rr (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en), .dmem_size(dmem_size),
      .dmem_zero_extend(dmem_zero_extend), .dmem_wdata(dmem_wdata), .dmem_gnt(b_dmem_gnt),
      .dmem_rvalid(b_dmem_rvalid), .dmem_rdata(b_dmem_rdata), .dmem_err(b_dmem_err),
      .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always_comb begin
      if (mon_rr) begin
         {o_if_gnt, o_if_rvalid, o_if_rdata, o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata, o_dmem_err} =
            {b_if_gnt, b_if_rvalid, b_if_rdata, b_dmem_gnt, b_dmem_rvalid, b_dmem_rdata, b_dmem_err};
         {o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata} =
            {b_mem_req, b_mem_addr, b_mem_we, b_mem_be, b_mem_wdata};
      end else begin
         {o_if_gnt, o_if_rvalid, o_if_rdata, o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata, o_dmem_err} =
            {a_if_gnt, a_if_rvalid, a_if_rdata, a_dmem_gnt, a_dmem_rvalid, a_dmem_rdata, a_dmem_err};
         {o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata} =
            {a_mem_req, a_mem_addr, a_mem_we, a_mem_be, a_mem_wdata};
      end
      o_all = {o_if_gnt, o_if_rvalid, o_if_rdata, o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata, o_dmem_err,
               o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata};
   end

   // Response scoreboard: every rvalid pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (o_if_rvalid || o_dmem_rvalid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got if_rvalid=%0b dmem_rvalid=%0b, required no response",
                     o_if_rvalid, o_dmem_rvalid);
         end else begin
            mon_e      = exp_q.pop_front();
            mon_g.is_d = o_dmem_rvalid;
            mon_g.data = o_dmem_rvalid ? o_dmem_rdata : o_if_rdata;
            mon_g.err  = o_dmem_rvalid ? o_dmem_err : 1'b0;
            if (mon_g !== mon_e || (o_if_rvalid && o_dmem_rvalid)) begin
               errors++;
               $display("FAIL rsp_match: got is_d=%0b data=%h err=%0b (both=%0b), required is_d=%0b data=%h err=%0b",
                        mon_g.is_d, mon_g.data, mon_g.err, o_if_rvalid && o_dmem_rvalid,
                        mon_e.is_d, mon_e.data, mon_e.err);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      if_req = 1'b0; if_addr = '0;
      dmem_req = 1'b0; dmem_addr = '0; dmem_wr_en = 1'b0; dmem_size = WORD;
      dmem_zero_extend = 1'b0; dmem_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      quiet();
      reset = 1'b1; if_req = 1'b1; dmem_req = 1'b1; dmem_addr = 32'h200; mem_gnt = 1'b1; mem_rvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (o_all !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required all zero", o_all);
      end
      cyc();
      quiet();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (o_all !== '0) begin
         errors++;
         $display("FAIL post_reset_outputs: got %h, required all zero", o_all);
      end
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
      cyc();
      if_req = 1'b1; if_addr = addr; mem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_if_gnt, o_mem_req, o_mem_we, o_mem_addr, o_mem_be} !== {1'b1, 1'b1, 1'b0, addr, 4'hF}) begin
         errors++;
         $display("FAIL fetch_req: got gnt=%0b req=%0b we=%0b addr=%h be=%h, required 1 1 0 %h f",
                  o_if_gnt, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, addr);
      end
      exp_q.push_back('{is_d: 1'b0, data: data, err: 1'b0});
      cyc();
      if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
      @(negedge clk);
      checks++;
      if (o_if_gnt !== 1'b0 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL busy_quiet: got gnt=%0b req=%0b, required 0 0", o_if_gnt, o_mem_req);
      end
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic data_access(input logic wr, input mem_size_t size, input logic zext,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrd,
                              input logic [31:0] exp_rd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      cyc();
      dmem_req = 1'b1; dmem_addr = addr; dmem_wr_en = wr; dmem_size = size;
      dmem_zero_extend = zext; dmem_wdata = wdata; mem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_dmem_gnt, o_mem_req, o_mem_we, o_mem_addr, o_mem_be} !==
          {1'b1, 1'b1, wr, addr & 32'hFFFF_FFFC, exp_be} || (wr && o_mem_wdata !== exp_wd)) begin
         errors++;
         $display("FAIL data_req @%h: got gnt=%0b req=%0b we=%0b addr=%h be=%h wdata=%h, required 1 1 %0b %h %h %h",
                  addr, o_dmem_gnt, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
                  wr, addr & 32'hFFFF_FFFC, exp_be, exp_wd);
      end
      exp_q.push_back('{is_d: 1'b1, data: exp_rd, err: 1'b0});
      cyc();
      dmem_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = mrd;
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_store_load();
      data_access(1'b1, BYTE,      1'b0, 32'h203, 32'h0000_00AB, 32'hDEAD_BEEF, 32'h0, 4'b1000, 32'hABAB_ABAB);
      data_access(1'b1, HALF_WORD, 1'b0, 32'h202, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 4'b1100, 32'h1234_1234);
      data_access(1'b1, WORD,      1'b0, 32'h204, 32'hCAFE_BABE, 32'h0,         32'h0, 4'b1111, 32'hCAFE_BABE);
      data_access(1'b0, BYTE,      1'b0, 32'h201, 32'h0, 32'h0000_F000, 32'hFFFF_FFF0, 4'hF, 32'h0);
      data_access(1'b0, BYTE,      1'b1, 32'h201, 32'h0, 32'h0000_F000, 32'h0000_00F0, 4'hF, 32'h0);
      data_access(1'b0, HALF_WORD, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 32'h0000_8001, 4'hF, 32'h0);
      data_access(1'b0, HALF_WORD, 1'b0, 32'h202, 32'h0, 32'h8001_0000, 32'hFFFF_8001, 4'hF, 32'h0);
      data_access(1'b0, WORD,      1'b0, 32'h208, 32'h0, 32'h1234_5678, 32'h1234_5678, 4'hF, 32'h0);
   endtask

   task automatic test_contention(input bit data_first);
      logic [31:0] first_dat, second_dat;
      first_dat  = data_first ? 32'h1122_3344 : 32'h5566_7788;
      second_dat = data_first ? 32'h5566_7788 : 32'h1122_3344;
      cyc();
      if_req = 1'b1; if_addr = 32'h104;
      dmem_req = 1'b1; dmem_addr = 32'h200; dmem_wr_en = 1'b0; dmem_size = WORD; mem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_dmem_gnt, o_if_gnt, o_mem_addr} !== {data_first, !data_first, data_first ? 32'h200 : 32'h104}) begin
         errors++;
         $display("FAIL first_grant(data_first=%0b): got dgnt=%0b ignt=%0b addr=%h", data_first,
                  o_dmem_gnt, o_if_gnt, o_mem_addr);
      end
      exp_q.push_back('{is_d: data_first, data: first_dat, err: 1'b0});
      cyc();
      if (data_first) dmem_req = 1'b0; else if_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = first_dat;
      @(negedge clk);
      checks++;
      if (o_dmem_gnt !== 1'b0 || o_if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL grant_in_busy: got dgnt=%0b ignt=%0b, required 0 0", o_dmem_gnt, o_if_gnt);
      end
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      @(negedge clk);
      checks++;
      if ({o_dmem_gnt, o_if_gnt, o_mem_addr} !== {!data_first, data_first, data_first ? 32'h104 : 32'h200}) begin
         errors++;
         $display("FAIL second_grant(data_first=%0b): got dgnt=%0b ignt=%0b addr=%h", data_first,
                  o_dmem_gnt, o_if_gnt, o_mem_addr);
      end
      exp_q.push_back('{is_d: !data_first, data: second_dat, err: 1'b0});
      cyc();
      if_req = 1'b0; dmem_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = second_dat;
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_errors();
      int lat;
      cyc();
      dmem_req = 1'b1; dmem_addr = 32'h202; dmem_wr_en = 1'b0; dmem_size = WORD; mem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if (o_dmem_gnt !== 1'b1 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_gnt: got gnt=%0b req=%0b, required 1 0", o_dmem_gnt, o_mem_req);
      end
      exp_q.push_back('{is_d: 1'b1, data: 32'h0, err: 1'b1});
      cyc();
      dmem_req = 1'b0;
      @(negedge clk);
      checks++;
      if (o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL err_state_req: got req=%0b, required 0", o_mem_req);
      end
      cyc();
      dmem_req = 1'b1; dmem_addr = 32'h300; mem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if (o_dmem_gnt !== 1'b1 || o_mem_req !== 1'b1) begin
         errors++;
         $display("FAIL timeout_gnt: got gnt=%0b req=%0b, required 1 1", o_dmem_gnt, o_mem_req);
      end
      exp_q.push_back('{is_d: 1'b1, data: 32'h0, err: 1'b1});
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         cyc();
         dmem_req = 1'b0; mem_gnt = 1'b0;
         @(negedge clk);
         if (o_dmem_rvalid) lat = i;
      end
      checks++;
      if (lat != 16) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles (0 = none in 40), required 16", lat);
      end
      cyc();
      mem_rvalid = 1'b1; mem_rdata = 32'h99;
      @(negedge clk);
      checks++;
      if (o_dmem_rvalid !== 1'b0 || o_if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL late_rvalid: got drv=%0b irv=%0b, required 0 0", o_dmem_rvalid, o_if_rvalid);
      end
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      dmem_req = 1'b1; dmem_addr = 32'h304; mem_gnt = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: 32'hA5A5_A5A5, err: 1'b0});
      for (int i = 0; i < 15; i++) begin
         cyc();
         dmem_req = 1'b0; mem_gnt = 1'b0;
      end
      cyc();
      mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL err_pending: got %0d outstanding responses, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      cyc();
      dmem_req = 1'b1; dmem_addr = 32'h400; dmem_wr_en = 1'b0; dmem_size = WORD; mem_gnt = 1'b1;
      cyc();
      dmem_req = 1'b0; mem_gnt = 1'b0;
      reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77; if_req = 1'b1; if_addr = 32'h500;
      @(negedge clk);
      checks++;
      if (o_all !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h, required all zero", o_all);
      end
      cyc();
      reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; if_req = 1'b0;
      fetch(32'h500, 32'h0BAD_F00D);
   endtask

   initial begin
      quiet();
      test_reset();
      fetch(32'h100, 32'h0050_0093);
      test_store_load();
      test_contention(1'b1);
      test_errors();
      test_reset_mid();
      cyc();
      reset = 1'b1;
      mon_rr = 1'b1;
      cyc();
      reset = 1'b0;
      data_access(1'b0, WORD, 1'b0, 32'h200, 32'h0, 32'h0102_0304, 32'h0102_0304, 4'hF, 32'h0);
      test_contention(1'b0);
      cyc();
      cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_pending: got %0d outstanding responses, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
